// File: rtl/apb4_pkg.sv
// -----------------------------------------------------------------------------
// apb4_pkg
// Shared types and helpers for the APB4 memory completer.
//   apb4_state_e : completer FSM states (IDLE, ACCESS)
//   apb4_ofs()   : byte-offset bit count inside one data word
//   apb4_req_t   : captured setup-phase request {addr, write, wdata, strb}
// The request struct is sized for the widest supported bus; narrower
// instances zero-fill the unused upper bits.
// -----------------------------------------------------------------------------
package apb4_pkg;

    localparam int APB4_MAX_AW = 32;
    localparam int APB4_MAX_DW = 1024;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb4_state_e;

    // Number of PADDR bits that select a byte within one DATA_WIDTH word.
    function automatic int apb4_ofs(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    typedef struct packed {
        logic [APB4_MAX_AW-1:0]   addr;
        logic                     write;
        logic [APB4_MAX_DW-1:0]   wdata;
        logic [APB4_MAX_DW/8-1:0] strb;
    } apb4_req_t;

endpackage

// File: rtl/apb4_mem_array.sv
// -----------------------------------------------------------------------------
// apb4_mem_array
// DEPTH x DATA_WIDTH register file, cleared asynchronously by rst.
//   clk, rst   : clock, async active-high clear of every word
//   we         : write enable (one word per cycle)
//   widx       : word index written when we=1
//   wdata      : write data
//   wstrb      : byte-lane enables for the write
//   ridx       : word index for the combinational read port
//   rdata      : mem[ridx], or 0 when ridx >= DEPTH
// -----------------------------------------------------------------------------
module apb4_mem_array #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [IDX_W-1:0]        widx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [IDX_W-1:0]        ridx,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (we) begin
            for (int w = 0; w < DEPTH; w++) begin
                if (widx == IDX_W'(w)) begin
                    for (int b = 0; b < NB; b++) begin
                        if (wstrb[b]) mem[w][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Compare-and-select read mux: indices past DEPTH fall through to zero
    // without ever forming an out-of-range array index.
    always_comb begin
        rdata = '0;
        for (int w = 0; w < DEPTH; w++) begin
            if (ridx == IDX_W'(w)) rdata = mem[w];
        end
    end

endmodule

// File: rtl/apb4_mem_slave.sv
// -----------------------------------------------------------------------------
// apb4_mem_slave
// APB4 completer fronting a byte-strobed register-file memory.
//   PCLK, PRESET : clock, async active-high reset (clears memory too)
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB : APB4 request
//   PRDATA       : read data, non-zero only on an error-free read completion
//   PREADY       : ACCESS phase complete after WAIT_STATES stall cycles
//   PSLVERR      : misaligned, out-of-range or read-only-write, on completion
//   ERR_CNT      : saturating count of error completions
// Request fields are taken from registers captured at the setup edge, so
// the outputs never depend combinationally on PADDR or PWDATA.
// -----------------------------------------------------------------------------
module apb4_mem_slave
    import apb4_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 16,
    parameter int WAIT_STATES = 0,
    parameter int RO_WORDS    = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic [7:0]              ERR_CNT
);

    localparam int OFS = apb4_ofs(DATA_WIDTH);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int IW  = ADDR_WIDTH - OFS;

    apb4_state_e             state;
    logic [3:0]              wcnt;
    apb4_req_t               req;
    apb4_req_t               cap;
    logic [7:0]              err_cnt;

    logic                    setup;
    logic                    pready;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [IW-1:0]           idx;
    logic                    misaligned;
    logic                    out_of_range;
    logic                    ro_hit;
    logic                    err;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    req_unused;

    // Zero-filled snapshot of the bus request for the capture registers.
    always_comb begin
        cap                   = '0;
        cap.addr[ADDR_WIDTH-1:0] = PADDR;
        cap.write             = PWRITE;
        cap.wdata[DATA_WIDTH-1:0] = PWDATA;
        cap.strb[NB-1:0]      = PSTRB;
    end

    // Upper struct bits beyond this instance's widths are always zero.
    assign req_unused = ^req;

    assign setup    = PSEL && !PENABLE;
    assign pready   = (state == ACCESS) && (wcnt == 4'(WAIT_STATES)) && PSEL && PENABLE;
    assign cur_addr = req.addr[ADDR_WIDTH-1:0];
    assign idx      = cur_addr[ADDR_WIDTH-1:OFS];

    generate
        if (OFS > 0) begin : g_align
            assign misaligned = |cur_addr[(OFS > 0 ? OFS-1 : 0):0];
        end else begin : g_noalign
            assign misaligned = 1'b0;
        end

        if (RO_WORDS > 0) begin : g_ro
            assign ro_hit = req.write && ({1'b0, idx} < (IW+1)'(RO_WORDS));
        end else begin : g_noro
            assign ro_hit = 1'b0;
        end
    endgenerate

    assign out_of_range = {1'b0, idx} >= (IW+1)'(MEM_DEPTH);
    assign err          = misaligned || out_of_range || ro_hit;

    assign mem_we  = pready && req.write && !err;

    assign PREADY  = pready;
    assign PSLVERR = pready && err;
    assign PRDATA  = (pready && !req.write && !err) ? mem_rdata : '0;
    assign ERR_CNT = err_cnt;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state   <= IDLE;
            wcnt    <= '0;
            req     <= '0;
            err_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // PENABLE without a preceding setup never starts a transfer.
                    if (setup) begin
                        req   <= cap;
                        wcnt  <= '0;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!PSEL) begin
                        state <= IDLE;          // abort: nothing committed
                    end else if (!PENABLE) begin
                        req  <= cap;            // restarted setup
                        wcnt <= '0;
                    end else if (pready) begin
                        state <= IDLE;
                        if (err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    apb4_mem_array #(
        .DEPTH      (MEM_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IW)
    ) u_mem (
        .clk   (PCLK),
        .rst   (PRESET),
        .we    (mem_we),
        .widx  (idx),
        .wdata (req.wdata[DATA_WIDTH-1:0]),
        .wstrb (req.strb[NB-1:0]),
        .ridx  (idx),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Directed bench: three instances share a clock.
//   dut 0 : defaults (no wait states, no read-only region)
//   dut 1 : WAIT_STATES=3, RO_WORDS=1
//   dut 2 : WAIT_STATES=2
module tb_apb4_mem_slave;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     [3];
    logic        psel    [3];
    logic        penable [3];
    logic        pwrite  [3];
    logic [7:0]  paddr   [3];
    logic [31:0] pwdata  [3];
    logic [3:0]  pstrb   [3];
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];
    logic [7:0]  err_cnt [3];

    int ncmp  = 0;
    int nfail = 0;

    apb4_mem_slave u_dut0 (
        .PCLK(clk), .PRESET(rst[0]), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]), .ERR_CNT(err_cnt[0])
    );

    apb4_mem_slave #(.WAIT_STATES(3), .RO_WORDS(1)) u_dut1 (
        .PCLK(clk), .PRESET(rst[1]), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]), .ERR_CNT(err_cnt[1])
    );

    apb4_mem_slave #(.WAIT_STATES(2)) u_dut2 (
        .PCLK(clk), .PRESET(rst[2]), .PSEL(psel[2]), .PENABLE(penable[2]),
        .PWRITE(pwrite[2]), .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PSTRB(pstrb[2]),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]), .ERR_CNT(err_cnt[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; drives setup, then access, waits for PREADY
    // (bounded) and returns at posedge+1 after the completing edge with the
    // bus still driven, so a following call is back-to-back.
    task automatic xfer(input int d, input bit wr, input logic [7:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic se, output int waits);
        bit done;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = a; pwdata[d] = wd; pstrb[d] = st;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        waits = 0; rd = '0; se = 1'b0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (pready[d]) begin
                rd = prdata[d]; se = pslverr[d]; done = 1'b1;
            end else begin
                waits++;
            end
        end
        if (!done) waits = -1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int d);
        psel[d] = 1'b0; penable[d] = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic        se;
    int          w;

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pready",  32'(pready[0]),  32'd0);
        chk("rst_prdata",  prdata[0],       32'd0);
        chk("rst_pslverr", 32'(pslverr[0]), 32'd0);
        chk("rst_errcnt",  32'(err_cnt[0]), 32'd0);
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        @(posedge clk); #1;

        // ---- dut 0: basic write/read, strobes, boundaries ----
        psel[0] = 1'b1; penable[0] = 1'b1;      // enable without setup
        @(negedge clk);
        chk("noset_pready", 32'(pready[0]), 32'd0);
        @(posedge clk); #1;
        idle(0);

        xfer(0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, rd, se, w);
        chk("a_wr_waits", 32'(w),  32'd0);
        chk("a_wr_err",   32'(se), 32'd0);
        idle(0);
        xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, rd, se, w);
        chk("a_rd_data",  rd,      32'hDEADBEEF);
        chk("a_rd_waits", 32'(w),  32'd0);
        chk("a_rd_err",   32'(se), 32'd0);
        idle(0);

        xfer(0, 1'b1, 8'h08, 32'h11223344, 4'b0101, rd, se, w);
        idle(0);
        xfer(0, 1'b0, 8'h08, 32'h0, 4'hF, rd, se, w);
        chk("a_strb_data", rd, 32'h00220044);
        idle(0);

        xfer(0, 1'b1, 8'h04, 32'hFFFFFFFF, 4'h0, rd, se, w);
        chk("a_nostrb_err", 32'(se), 32'd0);
        idle(0);
        xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, rd, se, w);
        chk("a_nostrb_data", rd, 32'hDEADBEEF);
        idle(0);

        xfer(0, 1'b1, 8'h3C, 32'h0BADF00D, 4'hF, rd, se, w);
        chk("a_last_wr_err", 32'(se), 32'd0);
        xfer(0, 1'b0, 8'h3C, 32'h0, 4'h0, rd, se, w);     // back-to-back
        chk("a_last_rd_data", rd, 32'h0BADF00D);
        chk("a_errcnt", 32'(err_cnt[0]), 32'd0);
        idle(0);

        // ---- dut 1: wait states, back-to-back, errors ----
        xfer(1, 1'b1, 8'h10, 32'hCAFEF00D, 4'hF, rd, se, w);
        chk("b_wr_waits", 32'(w), 32'd3);
        xfer(1, 1'b0, 8'h10, 32'h0, 4'h0, rd, se, w);
        chk("b_b2b_waits", 32'(w), 32'd3);
        chk("b_b2b_data",  rd,     32'hCAFEF00D);
        idle(1);

        xfer(1, 1'b0, 8'h41, 32'h0, 4'h0, rd, se, w);
        chk("b_misal_err",  32'(se), 32'd1);
        chk("b_misal_data", rd,      32'd0);
        idle(1);
        xfer(1, 1'b0, 8'h40, 32'h0, 4'h0, rd, se, w);
        chk("b_oor_err", 32'(se), 32'd1);
        idle(1);
        xfer(1, 1'b1, 8'h00, 32'hFFFFFFFF, 4'hF, rd, se, w);
        chk("b_ro_err", 32'(se), 32'd1);
        idle(1);
        chk("b_errcnt3", 32'(err_cnt[1]), 32'd3);
        xfer(1, 1'b0, 8'h00, 32'h0, 4'h0, rd, se, w);
        chk("b_ro_data", rd,      32'd0);
        chk("b_ro_rderr", 32'(se), 32'd0);
        idle(1);
        xfer(1, 1'b1, 8'h04, 32'h55AA55AA, 4'hF, rd, se, w);
        chk("b_firstrw_err", 32'(se), 32'd0);
        idle(1);
        xfer(1, 1'b0, 8'h04, 32'h0, 4'h0, rd, se, w);
        chk("b_firstrw_data", rd, 32'h55AA55AA);
        chk("b_errcnt_hold", 32'(err_cnt[1]), 32'd3);
        idle(1);

        // ---- dut 2: abort mid-wait, reset mid-access ----
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 8'h0C; pwdata[2] = 32'h12345678; pstrb[2] = 4'hF;
        @(posedge clk); #1;
        penable[2] = 1'b1;
        @(negedge clk);
        chk("c_wait_pready", 32'(pready[2]), 32'd0);
        @(posedge clk); #1;
        psel[2] = 1'b0; penable[2] = 1'b0;
        @(negedge clk);
        chk("c_abort_pready", 32'(pready[2]), 32'd0);
        @(posedge clk); #1;
        idle(2);
        xfer(2, 1'b0, 8'h0C, 32'h0, 4'h0, rd, se, w);
        chk("c_abort_data",  rd,     32'd0);
        chk("c_rd_waits",    32'(w), 32'd2);
        chk("c_abort_errcnt", 32'(err_cnt[2]), 32'd0);
        idle(2);

        xfer(2, 1'b0, 8'h41, 32'h0, 4'h0, rd, se, w);
        idle(2);
        chk("c_errcnt1", 32'(err_cnt[2]), 32'd1);
        xfer(2, 1'b1, 8'h0C, 32'hA5A5A5A5, 4'hF, rd, se, w);
        idle(2);
        xfer(2, 1'b0, 8'h0C, 32'h0, 4'h0, rd, se, w);
        chk("c_pre_rst_data", rd, 32'hA5A5A5A5);
        idle(2);

        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b0; paddr[2] = 8'h0C;
        @(posedge clk); #1;
        penable[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b1;
        #1;
        chk("c_rst_pready",  32'(pready[2]),  32'd0);
        chk("c_rst_prdata",  prdata[2],       32'd0);
        chk("c_rst_pslverr", 32'(pslverr[2]), 32'd0);
        chk("c_rst_errcnt",  32'(err_cnt[2]), 32'd0);
        @(posedge clk); #1;
        rst[2] = 1'b0;
        idle(2);
        xfer(2, 1'b0, 8'h0C, 32'h0, 4'h0, rd, se, w);
        chk("c_post_rst_data", rd,      32'd0);
        chk("c_post_rst_err",  32'(se), 32'd0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/apb4_mem_slave.md
# apb4_mem_slave

Parametrised APB4 completer: a byte-addressable register-file memory with byte strobes, a configurable wait-state count, a write-protected low region, and error signalling on bad accesses. It is the next-generation memory slave behind the APB bus top, generalised in data width, depth and response timing. It also keeps a saturating count of error responses for debug visibility.

## Interface
- ADDR_WIDTH, 8: PADDR width, byte address.
- DATA_WIDTH, 32: PWDATA/PRDATA width. Must be a multiple of 8 and a power of two, at least 8.
- MEM_DEPTH, 16: number of DATA_WIDTH words. Must be at least 1 and at most 2^(ADDR_WIDTH-OFS), where OFS = log2(DATA_WIDTH/8).
- WAIT_STATES, 0: PREADY-low cycles inserted in every ACCESS phase (0..15).
- RO_WORDS, 0: word indices below RO_WORDS are read-only (0..MEM_DEPTH).

Ports:
- PCLK  in  1  clock, rising edge.
- PRESET  in  1  reset, asynchronous, active-high.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  byte write strobes.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error response.
- ERR_CNT  out  8  saturating count of completed transfers that returned PSLVERR=1.

## Operation
- **States:** IDLE and ACCESS.
- **Request capture:**
  - In IDLE, PSEL=1 with PENABLE=0 is a setup.
  - On that edge, capture PADDR, PWRITE, PWDATA and PSTRB, clear the wait counter, and go to ACCESS.
  - In IDLE, PENABLE=1 without a prior setup is ignored.
- **ACCESS phase:**
  - PREADY = (state==ACCESS) && (wcnt==WAIT_STATES) && PSEL && PENABLE.
  - While PREADY=0, wcnt increments each cycle.
  - On the edge where PREADY=1, the transfer completes and the state returns to IDLE.
- **Abort:**
  - PSEL=0 in ACCESS aborts: go to IDLE, no memory write, ERR_CNT unchanged.
  - PSEL=1 with PENABLE=0 in ACCESS is treated as a new setup: recapture the request and clear wcnt.
- **Decode:** word index idx = captured PADDR[ADDR_WIDTH-1:OFS].
- **Error conditions (any one sets err):**
  - Misaligned: PADDR[OFS-1:0] != 0. Only applies when OFS > 0.
  - Out of range: idx >= MEM_DEPTH.
  - Write with idx < RO_WORDS.
- **Write completion:**
  - No error: byte lane b is written when PSTRB[b]=1.
  - PSTRB all zero: memory unchanged, OKAY response.
  - Error: memory unchanged.
- **Read completion:**
  - PRDATA = mem[idx] when PREADY=1 and err=0, otherwise 0.
  - PSTRB is ignored on reads.
- **PSLVERR:** equals err while PREADY=1, otherwise 0.
- **ERR_CNT:** increments on each completion with PSLVERR=1 and saturates at 255.
- **Reset:**
  - PRESET=1 forces IDLE, wcnt=0 and ERR_CNT=0, and clears all memory words to 0.
  - Outputs read PRDATA=0, PREADY=0, PSLVERR=0.
  - Reset mid-transfer discards the transfer with no write.

## Timing
- Zero wait states: setup edge, then the ACCESS cycle has PREADY=1. Two cycles per transfer.
- Total transfer length is 2 + WAIT_STATES cycles.
- PREADY, PRDATA and PSLVERR are combinational from registered state plus PSEL/PENABLE. No input-to-output path exists on PWDATA or PADDR.
- The memory write takes effect on the completing edge. A read of the same word in the next transfer returns the new data.
- Back-to-back transfers are supported: a setup may immediately follow completion, giving no idle gap.
- ERR_CNT updates on the completing edge and is visible the next cycle.

## Structure
- Package apb4_pkg holds:
  - the state enum (IDLE, ACCESS);
  - the localparam helper for OFS;
  - a request struct {addr, write, wdata, strb}.
- Sub-module apb4_mem_array: MEM_DEPTH x DATA_WIDTH register file with async clear, byte-enable write port and combinational read port.
- The top holds the FSM, capture registers, wait counter, decode/error logic and ERR_CNT.

## Test plan
- Defaults; write 0xDEADBEEF to 0x04 with PSTRB=4'hF, then read 0x04 → PRDATA=0xDEADBEEF, PSLVERR=0, two cycles each.
- Write 0x11223344 to 0x08 with PSTRB=4'b0101 over a zeroed word → read returns 0x00220044.
- WAIT_STATES=3 → PREADY low for 3 ACCESS cycles and high on the 4th. Back-to-back read follows with no gap.
- Read 0x41 (misaligned), read 0x40 (idx 16, out of range), and a write to 0x00 with RO_WORDS=1 → PSLVERR=1 on each, memory unchanged, ERR_CNT=3.
- Drop PSEL mid-wait on a write with WAIT_STATES=2 → no write, ERR_CNT unchanged. PRESET asserted mid-access → all outputs 0 and memory reads back 0.
